bank_write_controller: RTL and testbench

Sequences writes of a wide pixel stream into a double-buffered (ping-pong) RAM bank made of BLOCK_COUNT parallel blocks, each BLOCK_WIDTH bits wide. Generates write enable, address and per-block split data, so no separate block distributor is needed. Hands completed banks to the matrix readout side through a valid/done handshake. Sits between the DVI RX pixel packer and the bank RAMs; the video source cannot stall, so the block drops frames when no bank is free.

---
 rtl/bank_write_controller.sv | 160 ++++++++++++++++
 tb/tb_bank_write_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_write_controller.sv
// Writes a non-stallable wide pixel stream into a ping-pong bank of parallel RAM blocks.
// Latency: one cycle from an accepted beat to O_wr_en/addr/data; a bank is readable two cycles after its last beat.
// No backpressure: with no free bank the whole frame is dropped and counted; the reader frees banks via I_rd_done.
module bank_write_controller #(
    parameter int BLOCK_COUNT = 4,
    parameter int BLOCK_WIDTH = 32,
    parameter int DEPTH       = 512,
    parameter int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int BANDWIDTH   = BLOCK_COUNT * BLOCK_WIDTH
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    input  logic                   I_valid,
    input  logic                   I_sof,
    input  logic [BANDWIDTH-1:0]   I_data,
    output logic                   O_wr_en,
    output logic [ADDR_WIDTH:0]    O_wr_addr,
    output logic [BLOCK_WIDTH-1:0] O_wr_data [0:BLOCK_COUNT-1],
    output logic                   O_rd_valid,
    output logic                   O_rd_bank,
    input  logic                   I_rd_done,
    output logic [7:0]             O_drop_cnt,
    output logic                   O_sof_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_COMMIT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                 state_q, state_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [1:0]             bank_full_q, bank_full_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH:0]    wr_addr_q, wr_addr_d;
    logic [BLOCK_WIDTH-1:0] wr_data_q [0:BLOCK_COUNT-1];
    logic [BLOCK_WIDTH-1:0] wr_data_d [0:BLOCK_COUNT-1];
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   sof_err_q, sof_err_d;

    // Beat to be written this cycle and the word position it lands on
    logic                   do_wr;
    logic [ADDR_WIDTH-1:0]  wr_pos;
    logic                   rd_fire;

    // Next-state logic: frame sequencing, write port, bank ownership and drop counting
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        drop_cnt_d  = drop_cnt_q;
        sof_err_d   = 1'b0;
        do_wr       = 1'b0;
        wr_pos      = addr_q;

        case (state_q)
            S_IDLE: begin
                if (I_valid && I_sof) begin
                    if (bank_full_q[wr_bank_q]) begin
                        // Source cannot stall: lose the whole frame
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                    end else begin
                        do_wr  = 1'b1;
                        wr_pos = '0;
                    end
                end
            end
            S_FILL: begin
                if (I_valid) begin
                    do_wr = 1'b1;
                    if (I_sof) begin
                        // Early SOF restarts the frame in the same bank
                        sof_err_d = 1'b1;
                        wr_pos    = '0;
                    end
                end
            end
            S_COMMIT: begin
                // Beats in this cycle are discarded, including an SOF
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                addr_d                 = '0;
                state_d                = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, wr_pos};
            for (int i = 0; i < BLOCK_COUNT; i++) begin
                wr_data_d[i] = I_data[i*BLOCK_WIDTH +: BLOCK_WIDTH];
            end
            if (wr_pos == LAST_ADDR) begin
                state_d = S_COMMIT;
                addr_d  = '0;
            end else begin
                state_d = S_FILL;
                addr_d  = wr_pos + 1'b1;
            end
        end

        // Reader release; never collides with a commit since it targets the other bank
        rd_fire = I_rd_done && bank_full_q[rd_bank_q];
        if (rd_fire) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    // State and registered outputs; reset discards any partial frame
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '{default: '0};
            drop_cnt_q  <= 8'd0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            drop_cnt_q  <= drop_cnt_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign O_wr_en    = wr_en_q;
    assign O_wr_addr  = wr_addr_q;
    assign O_wr_data  = wr_data_q;
    assign O_rd_valid = bank_full_q[rd_bank_q];
    assign O_rd_bank  = rd_bank_q;
    assign O_drop_cnt = drop_cnt_q;
    assign O_sof_err  = sof_err_q;

endmodule

// File: tb/tb_bank_write_controller.sv
// Bench for bank_write_controller with DEPTH=4, BLOCK_COUNT=4, BLOCK_WIDTH=32.
// Directed scenarios check hand-derived constants; a random run checks a frame-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_bank_write_controller;

    localparam int BC    = 4;
    localparam int BW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic           I_clk = 1'b0;
    logic           I_rst;
    logic           I_valid;
    logic           I_sof;
    logic [127:0]   I_data;
    logic           I_rd_done;
    logic           O_wr_en;
    logic [AW:0]    O_wr_addr;
    logic [BW-1:0]  O_wr_data [0:BC-1];
    logic           O_rd_valid;
    logic           O_rd_bank;
    logic [7:0]     O_drop_cnt;
    logic           O_sof_err;

    int n_vec = 0;
    int n_err = 0;

    bank_write_controller #(
        .BLOCK_COUNT(BC),
        .BLOCK_WIDTH(BW),
        .DEPTH      (DEPTH)
    ) dut (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_valid   (I_valid),
        .I_sof     (I_sof),
        .I_data    (I_data),
        .O_wr_en   (O_wr_en),
        .O_wr_addr (O_wr_addr),
        .O_wr_data (O_wr_data),
        .O_rd_valid(O_rd_valid),
        .O_rd_bank (O_rd_bank),
        .I_rd_done (I_rd_done),
        .O_drop_cnt(O_drop_cnt),
        .O_sof_err (O_sof_err)
    );

    always #5 I_clk = ~I_clk;

    // Frame-level reference: position inside the current frame (-1 = waiting for SOF,
    // DEPTH = frame complete, handover pending), which bank each side owns, and which banks hold frames.
    int           m_pos;
    int           m_wbank;
    int           m_rbank;
    int           m_drops;
    bit           m_full [2];
    bit           e_wr_en;
    bit           e_sof_err;
    int           e_addr;
    logic [127:0] e_data;

    function automatic void model_reset();
        m_pos = -1; m_wbank = 0; m_rbank = 0; m_drops = 0;
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        e_wr_en = 1'b0; e_sof_err = 1'b0; e_addr = 0; e_data = '0;
    endfunction

    function automatic void model_step(logic v, logic s, logic [127:0] d, logic done);
        bit done_ok = done && m_full[m_rbank];
        int p = -1;
        e_wr_en   = 1'b0;
        e_sof_err = 1'b0;
        if (m_pos == DEPTH) begin
            m_full[m_wbank] = 1'b1;
            m_wbank = 1 - m_wbank;
            m_pos = -1;
        end else if (v) begin
            if (s && m_pos < 0 && m_full[m_wbank]) begin
                m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            end else if (s) begin
                e_sof_err = (m_pos >= 0);
                p = 0;
            end else if (m_pos >= 0) begin
                p = m_pos;
            end
        end
        if (p >= 0) begin
            e_wr_en = 1'b1;
            e_addr  = m_wbank * DEPTH + p;
            e_data  = d;
            m_pos   = p + 1;
        end
        if (done_ok) begin
            m_full[m_rbank] = 1'b0;
            m_rbank = 1 - m_rbank;
        end
    endfunction

    function automatic logic [127:0] wr_pack();
        logic [127:0] r;
        for (int i = 0; i < BC; i++) r[i*BW +: BW] = O_wr_data[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [127:0] d, input logic done);
        I_valid = v; I_sof = s; I_data = d; I_rd_done = done;
        model_step(v, s, d, done);
        @(posedge I_clk);
        #1;
    endtask

    task automatic do_reset();
        I_rst = 1'b1; I_valid = 1'b0; I_sof = 1'b0; I_data = '0; I_rd_done = 1'b0;
        model_reset();
        repeat (2) @(posedge I_clk);
        #1;
        I_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({O_wr_en, O_wr_addr, O_rd_valid, O_rd_bank, O_drop_cnt, O_sof_err} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got en=%b addr=%h rv=%b rb=%b drop=%0d serr=%b want all 0",
                     O_wr_en, O_wr_addr, O_rd_valid, O_rd_bank, O_drop_cnt, O_sof_err);
        end
        n_vec++;
        if (wr_pack() !== 128'd0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", wr_pack());
        end
    endtask

    // First frame into bank 0 plus per-block data split
    task automatic test_fill_split();
        logic [127:0] beats [4];
        beats[0] = 128'h44444444_33333333_22222222_11111111;
        beats[1] = {4{32'h02020202}};
        beats[2] = {4{32'h03030303}};
        beats[3] = {4{32'h04040404}};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, k == 0, beats[k], 1'b0);
            n_vec++;
            if ({O_wr_en, O_wr_addr, O_rd_valid} !== {1'b1, 3'(k), 1'b0}) begin
                n_err++; $display("FAIL fill_addr%0d: got en=%b addr=%0d rv=%b want en=1 addr=%0d rv=0",
                                  k, O_wr_en, O_wr_addr, O_rd_valid, k);
            end
            n_vec++;
            if (wr_pack() !== beats[k]) begin
                n_err++; $display("FAIL fill_data%0d: got %h want %h", k, wr_pack(), beats[k]);
            end
            if (k == 0) begin
                n_vec++;
                if (O_wr_data[0] !== 32'h11111111 || O_wr_data[3] !== 32'h44444444) begin
                    n_err++; $display("FAIL split: got blk0=%h blk3=%h want 11111111 44444444",
                                      O_wr_data[0], O_wr_data[3]);
                end
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_vec++;
        if ({O_wr_en, O_wr_addr, O_rd_valid, O_rd_bank} !== {1'b0, 3'd3, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL commit0: got en=%b addr=%0d rv=%b rb=%b want en=0 addr=3 rv=1 rb=0",
                              O_wr_en, O_wr_addr, O_rd_valid, O_rd_bank);
        end
    endtask

    // Second frame fills bank 1, third frame is dropped, reader frees bank 0
    task automatic test_drop();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, k == 0, rnd128(), 1'b0);
            n_vec++;
            if ({O_wr_en, O_wr_addr} !== {1'b1, 3'(4 + k)}) begin
                n_err++; $display("FAIL bank1_addr%0d: got en=%b addr=%0d want en=1 addr=%0d",
                                  k, O_wr_en, O_wr_addr, 4 + k);
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, rnd128(), 1'b0);
        n_vec++;
        if ({O_wr_en, O_drop_cnt, O_rd_valid, O_rd_bank} !== {1'b0, 8'd1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL drop: got en=%b drop=%0d rv=%b rb=%b want en=0 drop=1 rv=1 rb=0",
                              O_wr_en, O_drop_cnt, O_rd_valid, O_rd_bank);
        end
        cycle(1'b1, 1'b0, rnd128(), 1'b0);
        n_vec++;
        if (O_wr_en !== 1'b0) begin
            n_err++; $display("FAIL drop_tail: got en=%b want 0", O_wr_en);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_vec++;
        if ({O_rd_valid, O_rd_bank} !== 2'b11) begin
            n_err++; $display("FAIL rd_done: got rv=%b rb=%b want rv=1 rb=1", O_rd_valid, O_rd_bank);
        end
        cycle(1'b1, 1'b1, rnd128(), 1'b0);
        n_vec++;
        if ({O_wr_en, O_wr_addr} !== {1'b1, 3'd0}) begin
            n_err++; $display("FAIL reuse_bank0: got en=%b addr=%0d want en=1 addr=0", O_wr_en, O_wr_addr);
        end
    endtask

    // SOF on the second beat restarts the frame at address 0
    task automatic test_sof_restart();
        cycle(1'b1, 1'b1, rnd128(), 1'b0);
        n_vec++;
        if ({O_sof_err, O_wr_en, O_wr_addr} !== {1'b1, 1'b1, 3'd0}) begin
            n_err++; $display("FAIL sof_err: got serr=%b en=%b addr=%0d want serr=1 en=1 addr=0",
                              O_sof_err, O_wr_en, O_wr_addr);
        end
        for (int k = 1; k < 4; k++) begin
            cycle(1'b1, 1'b0, rnd128(), 1'b0);
            n_vec++;
            if ({O_sof_err, O_wr_en, O_wr_addr} !== {1'b0, 1'b1, 3'(k)}) begin
                n_err++; $display("FAIL restart_addr%0d: got serr=%b en=%b addr=%0d want serr=0 en=1 addr=%0d",
                                  k, O_sof_err, O_wr_en, O_wr_addr, k);
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_vec++;
        if ({O_rd_valid, O_rd_bank} !== 2'b10) begin
            n_err++; $display("FAIL restart_commit: got rv=%b rb=%b want rv=1 rb=0", O_rd_valid, O_rd_bank);
        end
    endtask

    // Asynchronous reset in the middle of a frame
    task automatic test_async_reset();
        cycle(1'b1, 1'b1, rnd128(), 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b0);
        #2;
        I_rst = 1'b1;
        #1;
        n_vec++;
        if ({O_wr_en, O_wr_addr, O_rd_valid, O_rd_bank, O_drop_cnt, O_sof_err} !== 15'd0 ||
            wr_pack() !== 128'd0) begin
            n_err++; $display("FAIL async_rst: got en=%b addr=%0d rv=%b drop=%0d data=%h want all 0",
                              O_wr_en, O_wr_addr, O_rd_valid, O_drop_cnt, wr_pack());
        end
        model_reset();
        @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        cycle(1'b1, 1'b1, rnd128(), 1'b0);
        n_vec++;
        if ({O_wr_en, O_wr_addr, O_drop_cnt} !== {1'b1, 3'd0, 8'd0}) begin
            n_err++; $display("FAIL post_rst: got en=%b addr=%0d drop=%0d want en=1 addr=0 drop=0",
                              O_wr_en, O_wr_addr, O_drop_cnt);
        end
    endtask

    // Commit of bank 1 coinciding with release of bank 0, then drop counter saturation
    task automatic test_commit_rd_done_sat();
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, rnd128(), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, rnd128(), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_vec++;
        if ({O_rd_valid, O_rd_bank} !== 2'b11) begin
            n_err++; $display("FAIL commit_and_done: got rv=%b rb=%b want rv=1 rb=1", O_rd_valid, O_rd_bank);
        end
        cycle(1'b1, 1'b1, rnd128(), 1'b0);
        n_vec++;
        if ({O_wr_en, O_wr_addr} !== {1'b1, 3'd0}) begin
            n_err++; $display("FAIL bank0_free: got en=%b addr=%0d want en=1 addr=0", O_wr_en, O_wr_addr);
        end
        for (int k = 1; k < 4; k++) cycle(1'b1, 1'b0, rnd128(), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b1, rnd128(), 1'b0);
            if (i == 253 || i == 254) begin
                n_vec++;
                if (O_drop_cnt !== 8'(i + 1)) begin
                    n_err++; $display("FAIL drop_cnt%0d: got %0d want %0d", i, O_drop_cnt, i + 1);
                end
            end
        end
        n_vec++;
        if ({O_drop_cnt, O_wr_en} !== {8'd255, 1'b0}) begin
            n_err++; $display("FAIL drop_sat: got drop=%0d en=%b want drop=255 en=0", O_drop_cnt, O_wr_en);
        end
    endtask

    // Random traffic against the frame-level model
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rnd128(),
                  $urandom_range(0, 5) == 0);
            n_vec++;
            if ({O_wr_en, O_sof_err, O_wr_addr} !== {e_wr_en, e_sof_err, 3'(e_addr)}) begin
                n_err++; $display("FAIL rnd_wr c=%0d: got en=%b serr=%b addr=%0d want en=%b serr=%b addr=%0d",
                                  c, O_wr_en, O_sof_err, O_wr_addr, e_wr_en, e_sof_err, e_addr);
            end
            n_vec++;
            if (wr_pack() !== e_data) begin
                n_err++; $display("FAIL rnd_data c=%0d: got %h want %h", c, wr_pack(), e_data);
            end
            n_vec++;
            if ({O_rd_valid, O_rd_bank, O_drop_cnt} !== {m_full[m_rbank], 1'(m_rbank), 8'(m_drops)}) begin
                n_err++; $display("FAIL rnd_rd c=%0d: got rv=%b rb=%b drop=%0d want rv=%b rb=%0d drop=%0d",
                                  c, O_rd_valid, O_rd_bank, O_drop_cnt, m_full[m_rbank], m_rbank, m_drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_split();
        test_drop();
        test_sof_restart();
        test_async_reset();
        test_commit_rd_done_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
